// File: rtl/tpu_ub_pkg.sv
// Shared types and default sizes for the N-bank unified buffer.
package tpu_ub_pkg;

  localparam int UB_DATA_WIDTH = 256;
  localparam int UB_DEPTH      = 128;
  localparam int UB_NUM_BANKS  = 2;
  localparam int UB_CW         = 9;
  localparam int UB_AW         = $clog2(UB_DEPTH);

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_DONE = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_STREAM = 2'd1,
    RD_DONE   = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [UB_AW-1:0] addr;
    logic [UB_CW-1:0] count;
  } ub_cmd_t;

endpackage

// File: rtl/ub_bank_ram.sv
// One buffer bank: sync write port, registered sync read port.
module ub_bank_ram
  import tpu_ub_pkg::*;
#(
  parameter int DATA_WIDTH = UB_DATA_WIDTH,
  parameter int DEPTH = UB_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] q
);

  (* ram_style = "block" *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/unified_buffer_nbank.sv
// Ring of NUM_BANKS banks with independent write and read burst engines.
module unified_buffer_nbank
  import tpu_ub_pkg::*;
#(
  parameter int DATA_WIDTH = UB_DATA_WIDTH,
  parameter int DEPTH = UB_DEPTH,
  parameter int NUM_BANKS = UB_NUM_BANKS,
  parameter int CW = UB_CW,
  localparam int AW = $clog2(DEPTH),
  localparam int BW = $clog2(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_cmd_valid,
  output logic                  wr_cmd_ready,
  input  logic [AW-1:0]         wr_cmd_addr,
  input  logic [CW-1:0]         wr_cmd_count,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_done,
  input  logic                  wr_commit,
  input  logic                  rd_cmd_valid,
  output logic                  rd_cmd_ready,
  input  logic [AW-1:0]         rd_cmd_addr,
  input  logic [CW-1:0]         rd_cmd_count,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_done,
  input  logic                  rd_release,
  output logic [BW:0]           filled,
  output logic                  busy,
  output logic                  err
);

  localparam logic [BW:0] FULL_LVL = (BW+1)'(NUM_BANKS);

  wr_state_e wr_state;
  rd_state_e rd_state;

  logic [BW-1:0] wr_ptr;
  logic [BW-1:0] rd_ptr;
  logic [AW-1:0] waddr;
  logic [CW-1:0] wcnt;
  logic [AW-1:0] raddr;
  logic [CW-1:0] rissue;
  logic [CW-1:0] rleft;
  logic          s1_v;

  logic full;
  logic empty;
  logic wr_beat;
  logic rd_adv;
  logic rd_issue;
  logic rd_take;
  logic commit_ok;
  logic release_ok;

  logic [DATA_WIDTH-1:0] bank_q [NUM_BANKS];

  assign full  = filled == FULL_LVL;
  assign empty = filled == '0;

  assign wr_cmd_ready = (wr_state == WR_IDLE) && !full;
  assign wr_ready     = wr_state == WR_DATA;
  assign wr_done      = wr_state == WR_DONE;
  assign wr_beat      = wr_valid && wr_ready;

  assign rd_cmd_ready = (rd_state == RD_IDLE) && !empty;
  assign rd_done      = rd_state == RD_DONE;
  // RAM output (stage 1) and rd_data (stage 2) move together
  assign rd_adv   = !rd_valid || rd_ready;
  assign rd_issue = (rd_state == RD_STREAM) && (rissue != '0) && rd_adv;
  assign rd_take  = rd_valid && rd_ready;

  assign commit_ok  = wr_commit && (wr_state == WR_IDLE) && !full;
  assign release_ok = rd_release && (rd_state == RD_IDLE) && !empty;

  assign busy = (wr_state != WR_IDLE) || (rd_state != RD_IDLE);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    ub_bank_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH(DEPTH)
    ) u_ram (
      .clk(clk),
      .we(wr_beat && (wr_ptr == BW'(b))),
      .waddr(waddr),
      .wdata(wr_data),
      .re(rd_issue && (rd_ptr == BW'(b))),
      .raddr(raddr),
      .q(bank_q[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= WR_IDLE;
      waddr    <= '0;
      wcnt     <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (wr_cmd_valid && wr_cmd_ready) begin
            waddr    <= wr_cmd_addr;
            wcnt     <= wr_cmd_count;
            wr_state <= (wr_cmd_count == '0) ? WR_DONE : WR_DATA;
          end
        end
        WR_DATA: begin
          if (wr_beat) begin
            waddr <= waddr + AW'(1);
            wcnt  <= wcnt - CW'(1);
            if (wcnt == CW'(1)) wr_state <= WR_DONE;
          end
        end
        WR_DONE: wr_state <= WR_IDLE;
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      raddr    <= '0;
      rissue   <= '0;
      rleft    <= '0;
      s1_v     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (rd_adv) begin
        rd_valid <= s1_v;
        s1_v     <= rd_issue;
        if (s1_v) rd_data <= bank_q[rd_ptr];
      end
      if (rd_issue) begin
        raddr  <= raddr + AW'(1);
        rissue <= rissue - CW'(1);
      end
      case (rd_state)
        RD_IDLE: begin
          if (rd_cmd_valid && rd_cmd_ready) begin
            raddr    <= rd_cmd_addr;
            rissue   <= rd_cmd_count;
            rleft    <= rd_cmd_count;
            rd_state <= (rd_cmd_count == '0) ? RD_DONE : RD_STREAM;
          end
        end
        RD_STREAM: begin
          if (rd_take) begin
            rleft <= rleft - CW'(1);
            if (rleft == CW'(1)) rd_state <= RD_DONE;
          end
        end
        RD_DONE: rd_state <= RD_IDLE;
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      filled <= '0;
      err    <= 1'b0;
    end else begin
      if (commit_ok)  wr_ptr <= wr_ptr + BW'(1);
      if (release_ok) rd_ptr <= rd_ptr + BW'(1);
      if (commit_ok && !release_ok) filled <= filled + (BW+1)'(1);
      if (release_ok && !commit_ok) filled <= filled - (BW+1)'(1);
      if ((wr_commit && !commit_ok) || (rd_release && !release_ok))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_unified_buffer_nbank.sv
// Bench for unified_buffer_nbank: ring-level model plus directed bursts.
module tb_unified_buffer_nbank;

  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int NB  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_cmd_valid = 1'b0;
  logic        wr_cmd_ready;
  logic [3:0]  wr_cmd_addr = '0;
  logic [8:0]  wr_cmd_count = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic        wr_done;
  logic        wr_commit = 1'b0;
  logic        rd_cmd_valid = 1'b0;
  logic        rd_cmd_ready;
  logic [3:0]  rd_cmd_addr = '0;
  logic [8:0]  rd_cmd_count = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic        rd_done;
  logic        rd_release = 1'b0;
  logic [2:0]  filled;
  logic        busy;
  logic        err;

  unified_buffer_nbank #(
    .DATA_WIDTH(DW), .DEPTH(DEP), .NUM_BANKS(NB), .CW(9)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_addr(wr_cmd_addr), .wr_cmd_count(wr_cmd_count),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_done(wr_done), .wr_commit(wr_commit),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_count(rd_cmd_count),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_done(rd_done), .rd_release(rd_release),
    .filled(filled), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL timeout %s", nm);
  endtask

  // Ring-level model: bank contents, occupancy and expected read stream
  logic [31:0] m_mem [NB][DEP];
  logic [31:0] exp_q [$];
  int m_filled, m_wp, m_rp, m_waddr, m_wleft, m_rleft;
  bit m_wact, m_wdone, m_ract, m_rdone, m_err;

  task automatic model_reset();
    m_filled = 0; m_wp = 0; m_rp = 0;
    m_waddr = 0; m_wleft = 0; m_rleft = 0;
    m_wact = 0; m_wdone = 0; m_ract = 0; m_rdone = 0; m_err = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit widle, ridle, c_ok, r_ok, nwd, nrd;
    int n;
    widle = !m_wact && !m_wdone;
    ridle = !m_ract && !m_rdone;
    c_ok = wr_commit && widle && (m_filled < NB);
    r_ok = rd_release && ridle && (m_filled > 0);
    nwd = 0;
    nrd = 0;
    if (m_wact && wr_valid) begin
      m_mem[m_wp][m_waddr] = wr_data;
      m_waddr = (m_waddr + 1) % DEP;
      m_wleft--;
      if (m_wleft == 0) begin m_wact = 0; nwd = 1; end
    end
    if (wr_cmd_valid && widle && (m_filled < NB)) begin
      m_waddr = int'(wr_cmd_addr);
      m_wleft = int'(wr_cmd_count);
      if (m_wleft == 0) nwd = 1; else m_wact = 1;
    end
    if (rd_valid && rd_ready && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      m_rleft--;
      if (m_rleft == 0) begin m_ract = 0; nrd = 1; end
    end
    if (rd_cmd_valid && ridle && (m_filled > 0)) begin
      n = int'(rd_cmd_count);
      for (int i = 0; i < n; i++)
        exp_q.push_back(m_mem[m_rp][(int'(rd_cmd_addr) + i) % DEP]);
      m_rleft = n;
      if (n == 0) nrd = 1; else m_ract = 1;
    end
    if (c_ok) m_wp = (m_wp + 1) % NB;
    if (r_ok) m_rp = (m_rp + 1) % NB;
    m_filled = m_filled + int'(c_ok) - int'(r_ok);
    if ((wr_commit && !c_ok) || (rd_release && !r_ok)) m_err = 1;
    m_wdone = nwd;
    m_rdone = nrd;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("filled", 64'(filled), 64'(m_filled));
      chk("err", 64'(err), 64'(m_err));
      chk("wr_ready", 64'(wr_ready), 64'(m_wact));
      chk("wr_done", 64'(wr_done), 64'(m_wdone));
      chk("rd_done", 64'(rd_done), 64'(m_rdone));
      chk("wr_cmd_ready", 64'(wr_cmd_ready),
          64'(!m_wact && !m_wdone && m_filled < NB));
      chk("rd_cmd_ready", 64'(rd_cmd_ready),
          64'(!m_ract && !m_rdone && m_filled > 0));
      chk("busy", 64'(busy),
          64'(m_wact || m_wdone || m_ract || m_rdone));
      if (rd_valid) begin
        chk("rd_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) chk("rd_data", 64'(rd_data), 64'(exp_q[0]));
      end
    end
  end

  logic [31:0] cap [$];
  int acc_cyc, first_cyc, last_cyc, done_cnt;

  task automatic do_reset();
    rst_n = 1'b0;
    wr_cmd_valid = 0; wr_valid = 0; wr_commit = 0;
    rd_cmd_valid = 0; rd_ready = 0; rd_release = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr_burst(input int a, input int n, input logic [31:0] base);
    int t;
    t = 0;
    wr_cmd_valid = 1; wr_cmd_addr = 4'(a); wr_cmd_count = 9'(n);
    while (!wr_cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin wr_cmd_valid = 0; tmo("wr_cmd"); return; end
    @(negedge clk);
    wr_cmd_valid = 0;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1; wr_data = base + 32'(i);
      t = 0;
      while (!wr_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin wr_valid = 0; tmo("wr_beat"); return; end
      @(negedge clk);
    end
    wr_valid = 0;
    t = 0;
    while (!wr_done && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin tmo("wr_done"); return; end
    @(negedge clk);
  endtask

  task automatic rd_burst(input int a, input int n, input logic [3:0] pat);
    int t, k;
    t = 0; k = 0;
    cap.delete(); first_cyc = -1; last_cyc = -1; done_cnt = 0;
    rd_cmd_valid = 1; rd_cmd_addr = 4'(a); rd_cmd_count = 9'(n);
    while (!rd_cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin rd_cmd_valid = 0; tmo("rd_cmd"); return; end
    acc_cyc = cyc + 1;
    @(negedge clk);
    rd_cmd_valid = 0;
    t = 0;
    while (done_cnt == 0 && t < 200) begin
      rd_ready = pat[k % 4];
      k++;
      if (rd_valid && first_cyc < 0) first_cyc = cyc;
      if (rd_valid && rd_ready) begin
        cap.push_back(rd_data);
        last_cyc = cyc;
      end
      if (rd_done) done_cnt++;
      @(negedge clk);
      t++;
    end
    rd_ready = 0;
    if (rd_done) done_cnt++;
    if (done_cnt == 0) tmo("rd_done");
  endtask

  task automatic commit();
    wr_commit = 1; @(negedge clk); wr_commit = 0;
  endtask

  task automatic release_bank();
    rd_release = 1; @(negedge clk); rd_release = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst wr_cmd_ready", 64'(wr_cmd_ready), 64'(1));
    chk("rst rd_cmd_ready", 64'(rd_cmd_ready), 64'(0));
    chk("rst filled", 64'(filled), 64'(0));
    chk("rst rd_valid", 64'(rd_valid), 64'(0));
    chk("rst rd_data", 64'(rd_data), 64'(0));
    chk("rst wr_ready", 64'(wr_ready), 64'(0));
    chk("rst err", 64'(err), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));

    wr_burst(0, 4, 32'hA0);
    commit();
    rd_burst(0, 4, 4'b1111);
    for (int i = 0; i < 4; i++) chk("basic data", 64'(cap[i]), 64'(32'hA0 + i));
    chk("basic latency", 64'(first_cyc - acc_cyc), 64'(2));
    chk("basic back2back", 64'(last_cyc - first_cyc), 64'(3));
    chk("basic done pulses", 64'(done_cnt), 64'(1));
    release_bank();

    wr_burst(0, 8, 32'hB0);
    commit();
    rd_burst(0, 8, 4'b1001);
    chk("stall count", 64'(cap.size()), 64'(8));
    for (int i = 0; i < 8; i++) chk("stall data", 64'(cap[i]), 64'(32'hB0 + i));
    chk("stall done pulses", 64'(done_cnt), 64'(1));
    release_bank();

    do_reset();
    for (int b = 0; b < 4; b++) begin
      wr_burst(4, 4, 32'hC000_0000 + 32'(b * 256));
      commit();
    end
    chk("full filled", 64'(filled), 64'(4));
    chk("full wr_cmd_ready", 64'(wr_cmd_ready), 64'(0));
    release_bank();
    chk("rel filled", 64'(filled), 64'(3));
    chk("rel wr_cmd_ready", 64'(wr_cmd_ready), 64'(1));
    wr_burst(4, 4, 32'hD000_0000);
    commit();
    chk("refill filled", 64'(filled), 64'(4));
    for (int b = 1; b < 4; b++) begin
      rd_burst(4, 4, 4'b1111);
      chk("bank intact", 64'(cap[0]), 64'(32'hC000_0000 + b * 256));
      chk("bank intact last", 64'(cap[3]), 64'(32'hC000_0003 + b * 256));
      release_bank();
    end
    rd_burst(4, 4, 4'b1111);
    chk("rewritten first", 64'(cap[0]), 64'(32'hD000_0000));
    chk("rewritten last", 64'(cap[3]), 64'(32'hD000_0003));
    release_bank();

    wr_burst(DEP - 2, 4, 32'hE0);
    commit();
    rd_burst(0, 2, 4'b1111);
    chk("wrap word0", 64'(cap[0]), 64'(32'hE2));
    chk("wrap word1", 64'(cap[1]), 64'(32'hE3));
    rd_burst(DEP - 2, 2, 4'b0110);
    chk("wrap word14", 64'(cap[0]), 64'(32'hE0));
    chk("wrap word15", 64'(cap[1]), 64'(32'hE1));
    release_bank();

    do_reset();
    release_bank();
    chk("empty release err", 64'(err), 64'(1));
    chk("empty release filled", 64'(filled), 64'(0));

    do_reset();
    wr_cmd_valid = 1; wr_cmd_addr = 4'd0; wr_cmd_count = 9'd2;
    t = 0;
    while (!wr_cmd_ready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    wr_cmd_valid = 0;
    chk("mid wr_ready", 64'(wr_ready), 64'(1));
    commit();
    chk("mid commit err", 64'(err), 64'(1));
    chk("mid commit filled", 64'(filled), 64'(0));
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1; wr_data = 32'h50 + 32'(i);
      @(negedge clk);
    end
    wr_valid = 0;
    repeat (2) @(negedge clk);
    commit();
    chk("late commit filled", 64'(filled), 64'(1));

    do_reset();
    wr_burst(0, 2, 32'h60);
    commit();
    wr_burst(0, 2, 32'h61);
    wr_commit = 1; rd_release = 1;
    @(negedge clk);
    wr_commit = 0; rd_release = 0;
    chk("dual filled", 64'(filled), 64'(1));
    chk("dual err", 64'(err), 64'(0));
    rd_burst(0, 2, 4'b1111);
    chk("dual next bank", 64'(cap[0]), 64'(32'h61));
    chk("dual next bank w1", 64'(cap[1]), 64'(32'h62));
    release_bank();

    do_reset();
    wr_burst(0, 4, 32'h70);
    commit();
    rd_cmd_valid = 1; rd_cmd_addr = 4'd0; rd_cmd_count = 9'd4;
    t = 0;
    while (!rd_cmd_ready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    rd_cmd_valid = 0;
    rd_ready = 0;
    repeat (4) @(negedge clk);
    chk("hold valid", 64'(rd_valid), 64'(1));
    chk("hold data", 64'(rd_data), 64'(32'h70));
    #2 rst_n = 1'b0;
    #1;
    chk("async rd_valid", 64'(rd_valid), 64'(0));
    chk("async filled", 64'(filled), 64'(0));
    chk("async rd_data", 64'(rd_data), 64'(0));
    chk("async busy", 64'(busy), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unified_buffer_nbank.md
# unified_buffer_nbank

N-bank generalisation of the TPU unified buffer: a ring of `NUM_BANKS` on-chip banks with independent read and write burst engines. A producer (DMA/host) fills the write bank and commits it; the consumer (systolic-array feeder) streams the oldest committed bank and releases it. It sits between the DMA/UART loader and the systolic-array input/weight FIFOs. New versus the double-buffered predecessor:
- per-beat write data with valid/ready;
- read backpressure;
- bank ownership tracked in hardware instead of a `buf_sel` pin.

## Interface
Parameters:
- `DATA_WIDTH`, 256, beat width in bits
- `DEPTH`, 128, words per bank (power of two); `AW = $clog2(DEPTH)`
- `NUM_BANKS`, 2, banks in ring (power of two, 2..8); `BW = $clog2(NUM_BANKS)`
- `CW`, 9, burst-count width

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `wr_cmd_valid` / `wr_cmd_ready`  in/out  1  write burst command handshake
- `wr_cmd_addr`  in  AW  start word in current write bank
- `wr_cmd_count`  in  CW  beats
- `wr_valid` / `wr_ready`  in/out  1  write beat handshake
- `wr_data`  in  DATA_WIDTH  beat data
- `wr_done`  out  1  one-cycle pulse, burst finished
- `wr_commit`  in  1  hand current write bank to reader
- `rd_cmd_valid` / `rd_cmd_ready`  in/out  1  read burst command handshake
- `rd_cmd_addr`  in  AW  start word in current read bank
- `rd_cmd_count`  in  CW  beats
- `rd_valid` / `rd_ready`  out/in  1  read beat handshake
- `rd_data`  out  DATA_WIDTH  beat data
- `rd_done`  out  1  one-cycle pulse, last beat accepted
- `rd_release`  in  1  free current read bank
- `filled`  out  BW+1  committed, unreleased banks
- `busy`  out  1  either engine active
- `err`  out  1  sticky: illegal commit/release/command attempted

## Operation
- Ring state:
  - `wr_ptr` and `rd_ptr` are BW-bit and wrap modulo `NUM_BANKS`.
  - `filled` ranges 0..NUM_BANKS. Full when `filled == NUM_BANKS`; empty when `filled == 0`.
- Write engine, states `WR_IDLE`, `WR_DATA`, `WR_DONE`:
  - `wr_cmd_ready = WR_IDLE && !full`. On accept, latch addr and count.
  - count 0 goes straight to `WR_DONE`; nonzero goes to `WR_DATA`.
  - In `WR_DATA`, `wr_ready = 1`. Each `wr_valid && wr_ready` beat writes bank `wr_ptr` at the current address, then address +1 (mod DEPTH, wraps) and count −1.
  - After the last beat, go to `WR_DONE`, which pulses `wr_done` and returns to `WR_IDLE`.
- Read engine, states `RD_IDLE`, `RD_STREAM`, `RD_DONE`:
  - `rd_cmd_ready = RD_IDLE && !empty`. On accept, latch addr and count.
  - In `RD_STREAM`, a read is issued when beats remain and (`!rd_valid || rd_ready`). `rd_data` is registered from bank `rd_ptr`.
  - `rd_valid` holds and `rd_data` stays stable while `rd_ready == 0`. Address wraps mod DEPTH.
  - When the last beat is accepted, go to `RD_DONE`, which pulses `rd_done` and returns to `RD_IDLE`.
  - count 0 goes `IDLE` → `DONE` with no beats.
- `wr_commit`:
  - Legal only in `WR_IDLE` with `!full`. Effect: `wr_ptr++`, `filled++`.
  - Otherwise ignored and `err` set.
- `rd_release`:
  - Legal only in `RD_IDLE` with `!empty`. Effect: `rd_ptr++`, `filled--`.
  - Otherwise ignored and `err` set.
- Simultaneous legal commit and release: both pointers advance and `filled` is unchanged.
- Read and write banks never alias while `0 < filled < NUM_BANKS`. When `filled == 0` the reader cannot start; when full the writer cannot start. No same-bank access is possible.
- `busy = (wr_state != WR_IDLE) || (rd_state != RD_IDLE)`.
- `err` is cleared only by reset.

## Timing
- Reset (async assert, sync deassert) returns:
  - both FSMs to IDLE and both pointers to 0;
  - `filled` = 0, `rd_valid` = 0, `rd_data` = 0;
  - `wr_done` = 0, `rd_done` = 0, `err` = 0, `wr_ready` = 0;
  - `wr_cmd_ready` = 1 and `rd_cmd_ready` = 0.
- Memory contents are not reset. Reset mid-burst abandons the burst; beats already written remain.
- Write: a beat accepted at edge t is readable by a read issued at t+1.
- Read: command accepted at edge t gives the first `rd_valid` at t+2. Throughput is 1 beat/cycle while `rd_ready = 1`.
- `wr_done` and `rd_done` assert one cycle after the final beat handshake.
- The next command is accepted no earlier than the cycle after the done pulse.
- `filled` updates the cycle after commit/release. `rd_cmd_ready` can rise the cycle after the first commit.

## Structure
- Package `tpu_ub_pkg`:
  - `wr_state_e` and `rd_state_e` enums;
  - `ub_cmd_t` struct {addr, count};
  - default-parameter localparams.
- Sub-module `ub_bank_ram`: one bank, one sync write port, one sync registered read port, `(* ram_style = "block" *)`. Instantiate `NUM_BANKS` copies with a generate loop; write/read enables are decoded from the pointers.
- Top: two FSMs, ring counter, output register/hold logic.

## Test plan
- Write 4 beats `0xA0..0xA3` at addr 0, commit, read count 4 with `rd_ready=1` → `rd_data` `0xA0..0xA3` on consecutive cycles, first valid 2 cycles after command; `rd_done` pulses once.
- Read 8 beats with `rd_ready` toggled 1,0,0,1,… → no beat lost or duplicated; `rd_data` stable while stalled.
- `NUM_BANKS=4`: fill and commit 4 banks → `filled=4`, `wr_cmd_ready=0`; release 1 → `filled=3`, `wr_cmd_ready=1`; bank 0 is rewritten without corrupting banks 1–3.
- Write at addr `DEPTH-2`, count 4 → words land at `DEPTH-2`, `DEPTH-1`, 0, 1 (wrap).
- Release while empty, and commit during `WR_DATA` → ignored, `err=1`, `filled` unchanged.
- Same-cycle commit and release with `filled=1` → `filled` stays 1, both pointers advance. Assert `rst_n` mid-read → `rd_valid=0` immediately, `filled=0`.
